// File: rtl/pipeline_control.sv
// Pipeline hazard controller: load-use, memory-wait and mul/div-wait stalls, plus branch flush.
// Control outputs are combinational from the registered FSM state; also keeps a stall-cycle counter.
module pipeline_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic        valid_ex,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    input  logic        branch_taken_ex,
    input  logic        muldiv_start_ex,
    input  logic        muldiv_done,
    input  logic        mem_req_ma,
    input  logic        mem_ready_ma,
    input  logic        cnt_clr,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_ma,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        bubble_ma,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        StRun        = 2'd0,
        StMemWait    = 2'd1,
        StMuldivWait = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        load_use;
    logic        mem_miss;

    assign load_use = valid_ex & mem_read_ex & (rd_ex != 5'd0) & valid_id &
                      ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
    assign mem_miss = mem_req_ma & ~mem_ready_ma;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_ma  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        bubble_ma = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            StRun, StMemWait: begin
                // A memory wait is held until mem_ready_ma, whether or not the request is still up.
                if (mem_miss || (state_q == StMemWait && !mem_ready_ma)) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    stall_ma = 1'b1;
                    state_d  = StMemWait;
                end else if (muldiv_start_ex) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    bubble_ma = 1'b1;
                    state_d   = StMuldivWait;
                end else if (branch_taken_ex) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = StRun;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = StRun;
                end else begin
                    state_d = StRun;
                end
            end
            StMuldivWait: begin
                if (muldiv_done) begin
                    state_d = StRun;
                end else begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    bubble_ma = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (cnt_clr) begin
            stall_count_d = 16'd0;
        end else if (stall_if && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized and directed bench for pipeline_control, checked against a rule-level reference model.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id, rs1_used_id, rs2_used_id, valid_ex, mem_read_ex;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        branch_taken_ex, muldiv_start_ex, muldiv_done;
    logic        mem_req_ma, mem_ready_ma, cnt_clr;
    logic        stall_if, stall_id, stall_ex, stall_ma, flush_id, bubble_ex, bubble_ma;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int          errors = 0;
    int          checks = 0;
    int          m_state;
    int unsigned m_count;

    pipeline_control dut (
        .clk(clk), .rst_n(rst_n),
        .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .valid_ex(valid_ex), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex), .muldiv_start_ex(muldiv_start_ex),
        .muldiv_done(muldiv_done), .mem_req_ma(mem_req_ma), .mem_ready_ma(mem_ready_ma),
        .cnt_clr(cnt_clr),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_ma(stall_ma),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .bubble_ma(bubble_ma),
        .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {stall_if, stall_id, stall_ex, stall_ma, flush_id, bubble_ex, bubble_ma};
    endfunction

    // Expected {stall_if,id,ex,ma, flush_id, bubble_ex, bubble_ma} and next state from the rules.
    function automatic void model_eval(output logic [6:0] ctl, output int nxt);
        bit lu, miss;
        lu = valid_ex && mem_read_ex && rd_ex != 0 && valid_id &&
             ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        miss = mem_req_ma && !mem_ready_ma;
        ctl = 7'b0;
        nxt = m_state;
        if (m_state == 2) begin
            if (muldiv_done) nxt = 0;
            else ctl = 7'b1110001;
        end else if (miss || (m_state == 1 && !mem_ready_ma)) begin
            ctl = 7'b1111000;
            nxt = 1;
        end else begin
            nxt = 0;
            if (muldiv_start_ex) begin ctl = 7'b1110001; nxt = 2; end
            else if (branch_taken_ex) ctl = 7'b0000110;
            else if (lu) ctl = 7'b1100010;
        end
    endfunction

    task automatic clear_inputs();
        valid_id = 0; rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
        valid_ex = 0; rd_ex = 0; mem_read_ex = 0; branch_taken_ex = 0;
        muldiv_start_ex = 0; muldiv_done = 0; mem_req_ma = 0; mem_ready_ma = 0; cnt_clr = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag);
        logic [6:0] ctl;
        int         nxt;
        @(negedge clk);
        model_eval(ctl, nxt);
        check_eq({tag, ":ctl"}, 32'(ctl_now()), 32'(ctl));
        check_eq({tag, ":state"}, 32'(state), 32'(m_state));
        check_eq({tag, ":cnt"}, 32'(stall_count), m_count);
        @(posedge clk);
        if (cnt_clr) m_count = 0;
        else if (ctl[6] && m_count != 32'hFFFF) m_count++;
        m_state = nxt;
        #1;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check_eq({tag, ":rst_state"}, 32'(state), 32'd0);
        check_eq({tag, ":rst_cnt"}, 32'(stall_count), 32'd0);
        check_eq({tag, ":rst_ctl"}, 32'(ctl_now()), 32'd0);
        m_state = 0;
        m_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        m_state = 0;
        m_count = 0;
        rst_n   = 1'b1;
        #3;
        do_reset("init");

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        valid_ex = 1; mem_read_ex = 1; rd_ex = 5; valid_id = 1; rs1_id = 5; rs1_used_id = 1;
        step("lu");
        clear_inputs();
        step("lu_after");
        check_eq("lu_count", 32'(stall_count), 32'd1);

        // rd_ex = 0 matching, and unused rs2 match: no stall.
        valid_ex = 1; mem_read_ex = 1; rd_ex = 0; valid_id = 1; rs1_id = 0; rs1_used_id = 1;
        step("lu_x0");
        rd_ex = 5; rs1_id = 1; rs2_id = 5; rs2_used_id = 0;
        step("lu_rs2_unused");
        clear_inputs();
        cnt_clr = 1;
        step("clr");
        cnt_clr = 0;

        // Memory miss for three cycles, branch held through it.
        mem_req_ma = 1; mem_ready_ma = 0; branch_taken_ex = 1;
        repeat (3) step("miss");
        mem_ready_ma = 1;
        step("miss_release");
        check_eq("miss_count", 32'(stall_count), 32'd3);
        clear_inputs();

        // Branch plus load-use together: branch wins.
        branch_taken_ex = 1; valid_ex = 1; mem_read_ex = 1; rd_ex = 7;
        valid_id = 1; rs2_id = 7; rs2_used_id = 1;
        step("br_lu");
        clear_inputs();

        // Mul/div start, done after four cycles.
        muldiv_start_ex = 1;
        step("md_start");
        muldiv_start_ex = 0; mem_req_ma = 1; branch_taken_ex = 1;
        repeat (3) step("md_wait");
        muldiv_done = 1;
        step("md_done");
        clear_inputs();
        step("md_after");
        check_eq("md_state_run", 32'(state), 32'd0);

        // Reset in the middle of a mul/div wait.
        muldiv_start_ex = 1;
        step("md2_start");
        muldiv_start_ex = 0;
        step("md2_wait");
        do_reset("md_rst");
        step("md_rst_after");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            valid_id        = 1'($urandom_range(0, 3) != 0);
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            rs1_used_id     = 1'($urandom);
            rs2_used_id     = 1'($urandom);
            valid_ex        = 1'($urandom_range(0, 3) != 0);
            rd_ex           = 5'($urandom_range(0, 3));
            mem_read_ex     = 1'($urandom);
            branch_taken_ex = 1'($urandom_range(0, 4) == 0);
            muldiv_start_ex = 1'($urandom_range(0, 9) == 0);
            muldiv_done     = 1'($urandom_range(0, 2) == 0);
            mem_req_ma      = 1'($urandom_range(0, 3) == 0);
            mem_ready_ma    = 1'($urandom_range(0, 2) != 0);
            cnt_clr         = 1'($urandom_range(0, 49) == 0);
            step("rnd");
        end

        // Counter saturation and clear priority.
        clear_inputs();
        mem_ready_ma = 1;
        step("sat_drain");
        cnt_clr = 1;
        step("sat_clr");
        cnt_clr = 0; mem_req_ma = 1; mem_ready_ma = 0;
        repeat (65534) step("sat_fill");
        check_eq("sat_fffe", 32'(stall_count), 32'hFFFE);
        repeat (3) step("sat_hold");
        check_eq("sat_ffff", 32'(stall_count), 32'hFFFF);
        cnt_clr = 1;
        step("sat_clr_win");
        clear_inputs();
        #4;
        check_eq("clr_wins", 32'(stall_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
